execute_stage: RTL and testbench

- RV32 integer execute stage with three parts: the decode→execute pipeline register, the forwarding-capable ALU, and the execute→memory pipeline register.
- Sits between the decoder/register-file/control unit and the data cache / MEM_WB stage.
- The external forwarding unit drives the operand mux selects from the source addresses this block exports.

---
 rtl/exec_pkg.sv | 28 ++
 rtl/exec_alu.sv | 56 +++++
 rtl/execute_stage.sv | 117 +++++++++++
 tb/tb_execute_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared widths, ALU function codes and forward-select encodings for the execute stage.
package exec_pkg;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int OPW = 5;
    localparam int CCW = 3;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // ALUop bit that swaps operand B from rs2 to the immediate.
    localparam int IMM_SEL_BIT = 4;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [CCW-1:0] CC_NONE = '0;
endpackage

// File: rtl/exec_alu.sv
// Operand forward muxes plus the combinational RV32 ALU.
// Zero latency, no backpressure; select code 11 falls back to register data.
module exec_alu
    import exec_pkg::*;
#(
    parameter int DW  = exec_pkg::DW,
    parameter int OPW = exec_pkg::OPW
) (
    input  logic [OPW-1:0] aluOp,
    input  logic [DW-1:0]  regData1,
    input  logic [DW-1:0]  regData2,
    input  logic [DW-1:0]  immValue,
    input  logic [1:0]     select1,
    input  logic [1:0]     select2,
    input  logic [DW-1:0]  aluMemResult,
    input  logic [DW-1:0]  memWbData,
    output logic [DW-1:0]  result,
    output logic [DW-1:0]  rs2Fwd
);
    logic [DW-1:0] opA;
    logic [DW-1:0] opB;
    logic [4:0]    shamt;

    always_comb begin
        case (select1)
            FWD_MEM: opA = aluMemResult;
            FWD_WB:  opA = memWbData;
            default: opA = regData1;
        endcase
        case (select2)
            FWD_MEM: rs2Fwd = aluMemResult;
            FWD_WB:  rs2Fwd = memWbData;
            default: rs2Fwd = regData2;
        endcase
        opB   = aluOp[IMM_SEL_BIT] ? immValue : rs2Fwd;
        shamt = opB[4:0];
    end

    always_comb begin
        result = '0;
        case (aluOp[3:0])
            ALU_ADD:   result = opA + opB;
            ALU_SUB:   result = opA - opB;
            ALU_SLL:   result = opA << shamt;
            ALU_SLT:   result = {{(DW-1){1'b0}}, ($signed(opA) < $signed(opB))};
            ALU_SLTU:  result = {{(DW-1){1'b0}}, (opA < opB)};
            ALU_XOR:   result = opA ^ opB;
            ALU_SRL:   result = opA >> shamt;
            ALU_SRA:   result = $signed(opA) >>> shamt;
            ALU_OR:    result = opA | opB;
            ALU_AND:   result = opA & opB;
            ALU_PASSB: result = opB;
            default:   result = '0;
        endcase
    end
endmodule

// File: rtl/execute_stage.sv
// RV32 execute stage: DEC_ALU register, forwarding ALU, ALU_MEM register (optional flush: EXEC_FLUSH_EN).
// Latency 2 edges from inputs to outputs; enable=0 freezes both registers, flush bubbles stage 1.
module execute_stage
    import exec_pkg::*;
#(
    parameter int DW  = exec_pkg::DW,
    parameter int AW  = exec_pkg::AW,
    parameter int OPW = exec_pkg::OPW,
    parameter int CCW = exec_pkg::CCW
) (
    input  logic           clk,
    input  logic           resetIn,
    input  logic           enable,
`ifdef EXEC_FLUSH_EN
    input  logic           flush,
`endif
    input  logic [DW-1:0]  dataReg1,
    input  logic [DW-1:0]  dataReg2,
    input  logic [AW-1:0]  dataS1AddrIn,
    input  logic [AW-1:0]  dataS2AddrIn,
    input  logic [AW-1:0]  writeBackAddrIn,
    input  logic [OPW-1:0] ALUop,
    input  logic [DW-1:0]  immValueIn,
    input  logic [CCW-1:0] dataCacheControlIn,
    input  logic           writeEnableReg,
    input  logic [1:0]     select1,
    input  logic [1:0]     select2,
    input  logic [DW-1:0]  regDataFromMEM_WB,
    output logic [AW-1:0]  dataS1AddrOut,
    output logic [AW-1:0]  dataS2AddrOut,
    output logic [DW-1:0]  dataOut,
    output logic [DW-1:0]  dataRs2Out,
    output logic [CCW-1:0] dataCacheControlOut,
    output logic           writeEnableOut,
    output logic [AW-1:0]  writeBackAddrOut
);
    logic [DW-1:0]  s1Data1;
    logic [DW-1:0]  s1Data2;
    logic [AW-1:0]  s1WbAddr;
    logic [OPW-1:0] s1AluOp;
    logic [DW-1:0]  s1Imm;
    logic [CCW-1:0] s1CacheCtrl;
    logic           s1WriteEn;

    logic [DW-1:0]  aluResult;
    logic [DW-1:0]  rs2Fwd;

    // Stage 1 exports its rs1/rs2 addresses directly so the forwarding unit
    // sees the addresses of the instruction currently in execute.
    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            s1Data1       <= '0;
            s1Data2       <= '0;
            dataS1AddrOut <= '0;
            dataS2AddrOut <= '0;
            s1WbAddr      <= '0;
            s1AluOp       <= '0;
            s1Imm         <= '0;
            s1CacheCtrl   <= '0;
            s1WriteEn     <= 1'b0;
`ifdef EXEC_FLUSH_EN
        end else if (flush) begin
            s1Data1       <= '0;
            s1Data2       <= '0;
            dataS1AddrOut <= '0;
            dataS2AddrOut <= '0;
            s1WbAddr      <= '0;
            s1AluOp       <= '0;
            s1Imm         <= '0;
            s1CacheCtrl   <= CC_NONE;
            s1WriteEn     <= 1'b0;
`endif
        end else if (enable) begin
            s1Data1       <= dataReg1;
            s1Data2       <= dataReg2;
            dataS1AddrOut <= dataS1AddrIn;
            dataS2AddrOut <= dataS2AddrIn;
            s1WbAddr      <= writeBackAddrIn;
            s1AluOp       <= ALUop;
            s1Imm         <= immValueIn;
            s1CacheCtrl   <= dataCacheControlIn;
            s1WriteEn     <= writeEnableReg;
        end
    end

    exec_alu #(
        .DW  (DW),
        .OPW (OPW)
    ) u_alu (
        .aluOp        (s1AluOp),
        .regData1     (s1Data1),
        .regData2     (s1Data2),
        .immValue     (s1Imm),
        .select1      (select1),
        .select2      (select2),
        .aluMemResult (dataOut),
        .memWbData    (regDataFromMEM_WB),
        .result       (aluResult),
        .rs2Fwd       (rs2Fwd)
    );

    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            dataOut             <= '0;
            dataRs2Out          <= '0;
            dataCacheControlOut <= '0;
            writeEnableOut      <= 1'b0;
            writeBackAddrOut    <= '0;
        end else if (enable) begin
            dataOut             <= aluResult;
            dataRs2Out          <= rs2Fwd;
            dataCacheControlOut <= s1CacheCtrl;
            writeEnableOut      <= s1WriteEn;
            writeBackAddrOut    <= s1WbAddr;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: reset, ALU ops, forwarding, stall, optional flush.
module tb_execute_stage;
    logic        clk;
    logic        resetIn;
    logic        enable;
`ifdef EXEC_FLUSH_EN
    logic        flush;
`endif
    logic [31:0] dataReg1, dataReg2, immValueIn, regDataFromMEM_WB;
    logic [4:0]  dataS1AddrIn, dataS2AddrIn, writeBackAddrIn, ALUop;
    logic [2:0]  dataCacheControlIn;
    logic        writeEnableReg;
    logic [1:0]  select1, select2;
    logic [4:0]  dataS1AddrOut, dataS2AddrOut, writeBackAddrOut;
    logic [31:0] dataOut, dataRs2Out;
    logic [2:0]  dataCacheControlOut;
    logic        writeEnableOut;

    int testCount = 0;
    int failCount = 0;

    execute_stage dut (
        .clk                 (clk),
        .resetIn             (resetIn),
        .enable              (enable),
`ifdef EXEC_FLUSH_EN
        .flush               (flush),
`endif
        .dataReg1            (dataReg1),
        .dataReg2            (dataReg2),
        .dataS1AddrIn        (dataS1AddrIn),
        .dataS2AddrIn        (dataS2AddrIn),
        .writeBackAddrIn     (writeBackAddrIn),
        .ALUop               (ALUop),
        .immValueIn          (immValueIn),
        .dataCacheControlIn  (dataCacheControlIn),
        .writeEnableReg      (writeEnableReg),
        .select1             (select1),
        .select2             (select2),
        .regDataFromMEM_WB   (regDataFromMEM_WB),
        .dataS1AddrOut       (dataS1AddrOut),
        .dataS2AddrOut       (dataS2AddrOut),
        .dataOut             (dataOut),
        .dataRs2Out          (dataRs2Out),
        .dataCacheControlOut (dataCacheControlOut),
        .writeEnableOut      (writeEnableOut),
        .writeBackAddrOut    (writeBackAddrOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: run exceeded 100000 time units");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issue one op with register-file operands and check its result two edges later.
    task automatic runOp(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] imm, input logic [4:0] op, input logic [31:0] expected);
        dataReg1   = r1;
        dataReg2   = r2;
        immValueIn = imm;
        ALUop      = op;
        select1    = 2'b00;
        select2    = 2'b00;
        step();
        step();
        check(tag, dataOut, expected);
    endtask

    initial begin
        resetIn            = 1'b0;
        enable             = 1'b1;
`ifdef EXEC_FLUSH_EN
        flush              = 1'b0;
`endif
        dataReg1           = 32'h11;
        dataReg2           = 32'h22;
        dataS1AddrIn       = 5'd3;
        dataS2AddrIn       = 5'd4;
        writeBackAddrIn    = 5'd7;
        ALUop              = 5'h00;
        immValueIn         = 32'h0;
        dataCacheControlIn = 3'b001;
        writeEnableReg     = 1'b1;
        select1            = 2'b00;
        select2            = 2'b00;
        regDataFromMEM_WB  = 32'h0;

        step(); step(); step();
        check("rst_dataOut", dataOut, 32'h0);
        check("rst_rs2Out", dataRs2Out, 32'h0);
        check("rst_we", {31'b0, writeEnableOut}, 32'h0);
        check("rst_cc", {29'b0, dataCacheControlOut}, 32'h0);
        check("rst_rd", {27'b0, writeBackAddrOut}, 32'h0);
        check("rst_s1addr", {27'b0, dataS1AddrOut}, 32'h0);
        check("rst_s2addr", {27'b0, dataS2AddrOut}, 32'h0);

        resetIn = 1'b1;
        runOp("add", 32'd5, 32'd3, 32'h0, 5'h00, 32'd8);
        check("add_rs2Out", dataRs2Out, 32'd3);
        check("add_rd", {27'b0, writeBackAddrOut}, 32'd7);
        check("add_cc", {29'b0, dataCacheControlOut}, 32'd1);
        check("add_we", {31'b0, writeEnableOut}, 32'd1);
        check("s1addr", {27'b0, dataS1AddrOut}, 32'd3);
        check("s2addr", {27'b0, dataS2AddrOut}, 32'd4);

        runOp("sub", 32'h0, 32'h1, 32'h0, 5'h01, 32'hFFFF_FFFF);
        runOp("slt", 32'hFFFF_FFFF, 32'h1, 32'h0, 5'h03, 32'h1);
        runOp("sltu", 32'hFFFF_FFFF, 32'h1, 32'h0, 5'h04, 32'h0);
        runOp("sll", 32'h1, 32'h21, 32'h0, 5'h02, 32'h2);
        runOp("srl", 32'h8000_0000, 32'h4, 32'h0, 5'h06, 32'h0800_0000);
        runOp("xor", 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0, 5'h05, 32'hF0F0_F0F0);
        runOp("or", 32'h0000_F0F0, 32'h0000_0F0F, 32'h0, 5'h08, 32'h0000_FFFF);
        runOp("and", 32'h0000_F0F0, 32'h0000_FF00, 32'h0, 5'h09, 32'h0000_F000);
        runOp("code12", 32'd5, 32'd3, 32'h0, 5'h0C, 32'h0);
        runOp("passb", 32'hDEAD_BEEF, 32'h0, 32'h1234_5000, 5'h1A, 32'h1234_5000);

        // Stall: outputs must hold while new inputs are presented.
        enable          = 1'b0;
        dataReg1        = 32'h0000_DEAD;
        ALUop           = 5'h10;
        immValueIn      = 32'h0;
        writeBackAddrIn = 5'd9;
        step(); step();
        check("stall_dataOut", dataOut, 32'h1234_5000);
        check("stall_rd", {27'b0, writeBackAddrOut}, 32'd7);
        enable = 1'b1;
        step(); step();
        check("resume_dataOut", dataOut, 32'h0000_DEAD);
        check("resume_rd", {27'b0, writeBackAddrOut}, 32'd9);

        // Asynchronous reset mid-stream, away from any clock edge.
        #2;
        resetIn = 1'b0;
        #1;
        check("arst_dataOut", dataOut, 32'h0);
        check("arst_we", {31'b0, writeEnableOut}, 32'h0);
        check("arst_rd", {27'b0, writeBackAddrOut}, 32'h0);
        check("arst_s1addr", {27'b0, dataS1AddrOut}, 32'h0);
        enable = 1'b0;
        step();
        check("arst_cc", {29'b0, dataCacheControlOut}, 32'h0);

        // Release, then ADDI followed by dependent ops using both forward paths.
        resetIn            = 1'b1;
        enable             = 1'b1;
        dataReg1           = 32'h0000_0007;
        dataReg2           = 32'h0;
        immValueIn         = 32'hFFFF_FFFD;
        ALUop              = 5'h10;
        writeBackAddrIn    = 5'd5;
        writeEnableReg     = 1'b1;
        dataCacheControlIn = 3'b000;
        step();
        check("lat_edge1_we", {31'b0, writeEnableOut}, 32'h0);
        check("lat_edge1_data", dataOut, 32'h0);

        dataReg1        = 32'h0000_0100;
        immValueIn      = 32'h1;
        writeBackAddrIn = 5'd6;
        step();
        check("addi_dataOut", dataOut, 32'h4);
        check("addi_rd", {27'b0, writeBackAddrOut}, 32'd5);
        check("addi_we", {31'b0, writeEnableOut}, 32'd1);

        select1         = 2'b01;
        dataReg1        = 32'h8000_0000;
        dataReg2        = 32'h0;
        immValueIn      = 32'd31;
        ALUop           = 5'h17;
        writeBackAddrIn = 5'd8;
        step();
        check("fwd_mem", dataOut, 32'h5);
        check("fwd_mem_rd", {27'b0, writeBackAddrOut}, 32'd6);

        select1           = 2'b00;
        select2           = 2'b10;
        regDataFromMEM_WB = 32'h8000_0000;
        dataReg1          = 32'h1;
        ALUop             = 5'h04;
        step();
        check("fwd_wb_sra", dataOut, 32'hFFFF_FFFF);
        check("fwd_wb_rs2Out", dataRs2Out, 32'h8000_0000);
        step();
        check("fwd_wb_sltu", dataOut, 32'h1);
        select2 = 2'b00;

`ifdef EXEC_FLUSH_EN
        // Flush a store while stalled: the bubble reaches stage 2 on the next advance.
        ALUop              = 5'h10;
        writeEnableReg     = 1'b1;
        dataCacheControlIn = 3'b010;
        writeBackAddrIn    = 5'd3;
        enable             = 1'b0;
        flush              = 1'b1;
        step();
        flush  = 1'b0;
        enable = 1'b1;
        step();
        check("flush_we", {31'b0, writeEnableOut}, 32'h0);
        check("flush_cc", {29'b0, dataCacheControlOut}, 32'h0);
        check("flush_rd", {27'b0, writeBackAddrOut}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
